// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encodings, load-type codes and EX/MEM bus field offsets
// for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_BUS    = 6;
  localparam int HILO_WD      = 66;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  // Field offsets inside ex_to_mem_bus
  localparam int EX_PC_LSB       = 44;
  localparam int EX_RAM_EN_BIT   = 43;
  localparam int EX_RAM_WEN_LSB  = 39;
  localparam int EX_SEL_RES_BIT  = 38;
  localparam int EX_RF_WE_BIT    = 37;
  localparam int EX_RF_WADDR_LSB = 32;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'b000,
    LOAD_LB   = 3'b001,
    LOAD_LBU  = 3'b010,
    LOAD_LH   = 3'b011,
    LOAD_LHU  = 3'b100,
    LOAD_LW   = 3'b101
  } load_type_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Little-endian byte/half/word selection and sign/zero extension of SRAM load data.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Misaligned halves ignore addr[0]
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    load_data = 32'd0;
    case (load_type)
      LOAD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: load_data = {24'd0, byte_sel};
      LOAD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: load_data = {16'd0, half_sel};
      LOAD_LW:  load_data = rdata;
      default:  load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load-data hold buffer, MEM/WB buses and
// forwarding to ID. Optional macro MEM_LOAD_FWD_EN forwards extracted load data.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [2:0]              ex_load_type,
  input  logic [HILO_WD-1:0]      hilo_ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [HILO_WD-1:0]      hilo_mem_to_wb_bus,
  output logic                    mem_wreg,
  output logic [4:0]              mem_waddr,
  output logic [31:0]             mem_wdata,
  output logic                    mem_hi_we,
  output logic                    mem_lo_we,
  output logic [31:0]             mem_hi_wdata,
  output logic [31:0]             mem_lo_wdata,
  output logic                    mem_opl,
  output buf_state_e              dbg_buf_state
);

  logic [EX_TO_MEM_WD-1:0] ex_bus_q, ex_bus_d;
  logic [2:0]              load_type_q, load_type_d;
  logic [HILO_WD-1:0]      hilo_q, hilo_d;
  buf_state_e              buf_state_q, buf_state_d;
  logic [31:0]             rdata_buf_q, rdata_buf_d;

  logic        reg_load, reg_bubble, is_load;
  logic [31:0] pc, ex_result, rdata_sel, load_data, rf_wdata;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;
  logic        ram_en, sel_rf_res, rf_we;

  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  assign pc         = ex_bus_q[EX_PC_LSB +: 32];
  assign ram_en     = ex_bus_q[EX_RAM_EN_BIT];
  assign ram_wen    = ex_bus_q[EX_RAM_WEN_LSB +: 4];
  assign sel_rf_res = ex_bus_q[EX_SEL_RES_BIT];
  assign rf_we      = ex_bus_q[EX_RF_WE_BIT];
  assign rf_waddr   = ex_bus_q[EX_RF_WADDR_LSB +: 5];
  assign ex_result  = ex_bus_q[31:0];

  assign is_load = ram_en && (ram_wen == 4'd0) && (load_type_q != LOAD_NONE);

  always_comb begin
    reg_bubble  = (stall[STALL_EX_MEM] == STOP) && (stall[STALL_MEM_WB] == NO_STOP);
    reg_load    = (stall[STALL_EX_MEM] == NO_STOP);
    ex_bus_d    = ex_bus_q;
    load_type_d = load_type_q;
    hilo_d      = hilo_q;
    if (reg_bubble) begin
      ex_bus_d    = '0;
      load_type_d = '0;
      hilo_d      = '0;
    end else if (reg_load) begin
      ex_bus_d    = ex_to_mem_bus;
      load_type_d = ex_load_type;
      hilo_d      = hilo_ex_to_mem_bus;
    end
  end

  // Keeps the SRAM read result alive while a load is frozen in MEM
  always_comb begin
    buf_state_d = buf_state_q;
    rdata_buf_d = rdata_buf_q;
    case (buf_state_q)
      BUF_EMPTY: begin
        if (!reg_load && !reg_bubble && is_load && (stall[STALL_MEM_WB] == STOP)) begin
          buf_state_d = BUF_FULL;
          rdata_buf_d = data_sram_rdata;
        end
      end
      BUF_FULL: begin
        if (reg_load || reg_bubble) buf_state_d = BUF_EMPTY;
      end
      default: buf_state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_bus_q    <= '0;
      load_type_q <= '0;
      hilo_q      <= '0;
      buf_state_q <= BUF_EMPTY;
      rdata_buf_q <= '0;
    end else begin
      ex_bus_q    <= ex_bus_d;
      load_type_q <= load_type_d;
      hilo_q      <= hilo_d;
      buf_state_q <= buf_state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign rdata_sel = (buf_state_q == BUF_FULL) ? rdata_buf_q : data_sram_rdata;

  mem_load_align u_align (
    .rdata     (rdata_sel),
    .addr_lo   (ex_result[1:0]),
    .load_type (load_type_q),
    .load_data (load_data)
  );

  assign rf_wdata      = sel_rf_res ? load_data : ex_result;
  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};

  assign hilo_mem_to_wb_bus = hilo_q;
  assign mem_hi_wdata       = hilo_q[65:34];
  assign mem_lo_wdata       = hilo_q[33:2];
  assign mem_hi_we          = hilo_q[1];
  assign mem_lo_we          = hilo_q[0];

  assign mem_wreg  = rf_we;
  assign mem_waddr = rf_waddr;

`ifdef MEM_LOAD_FWD_EN
  assign mem_wdata = rf_wdata;
  assign mem_opl   = 1'b0;
`else
  assign mem_wdata = ex_result;
  assign mem_opl   = is_load;
`endif

  assign dbg_buf_state = buf_state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table through a scoreboard plus hand-written
// stall-hold, bubble and reset-while-full sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk;
  logic                    rst;
  logic [STALL_BUS-1:0]    stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [2:0]              ex_load_type;
  logic [HILO_WD-1:0]      hilo_ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [HILO_WD-1:0]      hilo_mem_to_wb_bus;
  logic                    mem_wreg;
  logic [4:0]              mem_waddr;
  logic [31:0]             mem_wdata;
  logic                    mem_hi_we, mem_lo_we;
  logic [31:0]             mem_hi_wdata, mem_lo_wdata;
  logic                    mem_opl;
  buf_state_e              dbg_buf_state;

  int errors = 0;
  int checks = 0;

  logic [MEM_TO_WB_WD-1:0] exp_q[$];
  logic [HILO_WD-1:0]      exp_hilo_q[$];

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .ex_to_mem_bus      (ex_to_mem_bus),
    .ex_load_type       (ex_load_type),
    .hilo_ex_to_mem_bus (hilo_ex_to_mem_bus),
    .data_sram_rdata    (data_sram_rdata),
    .mem_to_wb_bus      (mem_to_wb_bus),
    .hilo_mem_to_wb_bus (hilo_mem_to_wb_bus),
    .mem_wreg           (mem_wreg),
    .mem_waddr          (mem_waddr),
    .mem_wdata          (mem_wdata),
    .mem_hi_we          (mem_hi_we),
    .mem_lo_we          (mem_lo_we),
    .mem_hi_wdata       (mem_hi_wdata),
    .mem_lo_wdata       (mem_lo_wdata),
    .mem_opl            (mem_opl),
    .dbg_buf_state      (dbg_buf_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] res;
    logic [2:0]  lt;
    logic [65:0] hilo;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_load;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [75:0] make_bus(input logic [31:0] pc, input logic en,
                                           input logic [3:0] wen, input logic sel,
                                           input logic we, input logic [4:0] waddr,
                                           input logic [31:0] res);
    return {pc, en, wen, sel, we, waddr, res};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: place one instruction on the EX side with no stall
  task automatic drive(input vec_t v);
    ex_to_mem_bus      = make_bus(v.pc, v.ram_en, v.wen, v.sel, v.we, v.waddr, v.res);
    ex_load_type       = v.lt;
    hilo_ex_to_mem_bus = v.hilo;
    stall              = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wb"},    70'(mem_to_wb_bus), 70'd0);
    check({tag, " hilo"},  70'(hilo_mem_to_wb_bus), 70'd0);
    check({tag, " wreg"},  70'(mem_wreg), 70'd0);
    check({tag, " wdata"}, 70'(mem_wdata), 70'd0);
    check({tag, " opl"},   70'(mem_opl), 70'd0);
    check({tag, " hi_we"}, 70'(mem_hi_we), 70'd0);
    check({tag, " buf"},   70'(dbg_buf_state), 70'(BUF_EMPTY));
  endtask

  logic [69:0] exp_wb;
  logic [65:0] exp_hilo;
  logic        exp_opl;
  logic [31:0] exp_fwd;
  vec_t        v;

  initial begin
    vecs[0] = '{"lb",   32'hBFC0_0000, 1, 4'h0, 1, 1, 5'd2,  32'h0000_1003, LOAD_LB,   66'd0, 32'h80FF_1234, 32'hFFFF_FF80, 1};
    vecs[1] = '{"lbu",  32'hBFC0_0004, 1, 4'h0, 1, 1, 5'd3,  32'h0000_1003, LOAD_LBU,  66'd0, 32'h80FF_1234, 32'h0000_0080, 1};
    vecs[2] = '{"lh",   32'hBFC0_0008, 1, 4'h0, 1, 1, 5'd4,  32'h0000_1002, LOAD_LH,   66'd0, 32'h8001_7FFF, 32'hFFFF_8001, 1};
    vecs[3] = '{"lhu",  32'hBFC0_000C, 1, 4'h0, 1, 1, 5'd5,  32'h0000_1000, LOAD_LHU,  66'd0, 32'h8001_7FFF, 32'h0000_7FFF, 1};
    vecs[4] = '{"lw",   32'hBFC0_0010, 1, 4'h0, 1, 1, 5'd6,  32'h0000_1004, LOAD_LW,   66'd0, 32'h1234_5678, 32'h1234_5678, 1};
    vecs[5] = '{"lb1",  32'hBFC0_0014, 1, 4'h0, 1, 1, 5'd7,  32'h0000_1001, LOAD_LB,   66'd0, 32'h80FF_1234, 32'h0000_0012, 1};
    vecs[6] = '{"lbu2", 32'hBFC0_0018, 1, 4'h0, 1, 1, 5'd8,  32'h0000_1002, LOAD_LBU,  66'd0, 32'h80FF_1234, 32'h0000_00FF, 1};
    vecs[7] = '{"lh_mis", 32'hBFC0_001C, 1, 4'h0, 1, 1, 5'd10, 32'h0000_1003, LOAD_LH, 66'd0, 32'h80FF_1234, 32'hFFFF_80FF, 1};
    vecs[8] = '{"alu_hi", 32'hBFC0_0020, 0, 4'h0, 0, 1, 5'd9, 32'h0000_0042, LOAD_NONE,
                {32'h0000_ABCD, 32'h0, 1'b1, 1'b0}, 32'hFFFF_FFFF, 32'h0000_0042, 0};
    vecs[9] = '{"store_lo", 32'hBFC0_0024, 1, 4'hF, 0, 0, 5'd0, 32'h0000_2000, LOAD_NONE,
                {32'h0, 32'h1234_5678, 1'b0, 1'b1}, 32'h55AA_55AA, 32'h0000_2000, 0};

    rst = 1'b1;
    stall = '0;
    ex_to_mem_bus = '0;
    ex_load_type = '0;
    hilo_ex_to_mem_bus = '0;
    data_sram_rdata = 32'h5A5A_5A5A;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Table: one instruction per cycle, checked in the cycle it occupies MEM
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      drive(v);
      exp_q.push_back({v.pc, v.we, v.waddr, v.exp_wdata});
      exp_hilo_q.push_back(v.hilo);
      @(posedge clk);
      #1;
      data_sram_rdata = v.rdata;
      #1;
      exp_wb   = exp_q.pop_front();
      exp_hilo = exp_hilo_q.pop_front();
`ifdef MEM_LOAD_FWD_EN
      exp_opl = 1'b0;
      exp_fwd = v.exp_wdata;
`else
      exp_opl = v.exp_load;
      exp_fwd = v.res;
`endif
      check({v.name, " wb"},     70'(mem_to_wb_bus), exp_wb);
      check({v.name, " hilo"},   70'(hilo_mem_to_wb_bus), 70'(exp_hilo));
      check({v.name, " opl"},    70'(mem_opl), 70'(exp_opl));
      check({v.name, " fwd"},    70'({mem_wreg, mem_waddr, mem_wdata}), 70'({v.we, v.waddr, exp_fwd}));
      check({v.name, " hi_fwd"}, 70'({mem_hi_we, mem_hi_wdata}), 70'({v.hilo[1], v.hilo[65:34]}));
      check({v.name, " lo_fwd"}, 70'({mem_lo_we, mem_lo_wdata}), 70'({v.hilo[0], v.hilo[33:2]}));
    end

    // lw frozen in MEM: first read must be held while the SRAM output moves on
    v = '{"hold_lw", 32'hBFC0_0100, 1, 4'h0, 1, 1, 5'd3, 32'h0000_1000, LOAD_LW, 66'd0, 32'h0, 32'hDEAD_BEEF, 1};
    drive(v);
    exp_q.push_back({v.pc, v.we, v.waddr, 32'hDEAD_BEEF});
    @(posedge clk);
    #1;
    stall = 6'b011111;
    data_sram_rdata = 32'hDEAD_BEEF;
    ex_to_mem_bus = make_bus(32'hBFC0_0104, 0, 4'h0, 0, 1, 5'd11, 32'h0000_0077);
    ex_load_type = LOAD_NONE;
    hilo_ex_to_mem_bus = {32'h0000_1111, 32'h0000_2222, 1'b1, 1'b1};
    #1;
    check("hold first cycle", 70'(mem_to_wb_bus[31:0]), 70'h0DEAD_BEEF);
    check("hold buf empty",   70'(dbg_buf_state), 70'(BUF_EMPTY));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      data_sram_rdata = 32'h1111_1111;
      #1;
      check("hold buf full", 70'(dbg_buf_state), 70'(BUF_FULL));
      check("hold data",     70'(mem_to_wb_bus[31:0]), 70'h0DEAD_BEEF);
    end
    stall = '0;
    #1;
    check("hold release wb", 70'(mem_to_wb_bus), exp_q.pop_front());
    @(posedge clk);
    #1;
    check("hold buf emptied", 70'(dbg_buf_state), 70'(BUF_EMPTY));
    check("hold next wb",     70'(mem_to_wb_bus), {32'hBFC0_0104, 1'b1, 5'd11, 32'h0000_0077});
    check("hold next hilo",   70'(hilo_mem_to_wb_bus), 70'({32'h0000_1111, 32'h0000_2222, 1'b1, 1'b1}));

    // EX/MEM frozen while MEM/WB advances: a bubble enters MEM
    stall = 6'b001000;
    @(posedge clk);
    #1;
    check("bubble wb",   70'(mem_to_wb_bus), 70'd0);
    check("bubble hilo", 70'(hilo_mem_to_wb_bus), 70'd0);

    // Reset while the buffer is holding a load
    v = '{"rst_lw", 32'hBFC0_0200, 1, 4'h0, 1, 1, 5'd12, 32'h0000_1008, LOAD_LW,
          {32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1}, 32'h0, 32'hCAFE_F00D, 1};
    drive(v);
    @(posedge clk);
    #1;
    stall = 6'b011111;
    data_sram_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    data_sram_rdata = 32'h0BAD_0BAD;
    #1;
    check("rst pre buf full", 70'(dbg_buf_state), 70'(BUF_FULL));
    check("rst pre data",     70'(mem_to_wb_bus[31:0]), 70'h0CAFE_F00D);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst mid-stall");
    rst = 1'b0;
    stall = '0;
    @(posedge clk);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EX stage.
- Registers the EX/MEM bus and HI/LO bus under the global stall vector.
- Extracts and extends load data from the synchronous data SRAM; holds that data if MEM is stalled after the read returns.
- Produces the MEM/WB buses and the MEM-stage forwarding outputs to ID.

Parameters:
- None. Widths come from the shared defines: EX_TO_MEM_WD=76, MEM_TO_WB_WD=70, StallBus=6.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- stall  in  StallBus  global stall vector; stall[3]=EX/MEM register, stall[4]=MEM/WB register; Stop=1
- ex_to_mem_bus  in  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- ex_load_type  in  3  from EX: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw
- hilo_ex_to_mem_bus  in  66  {hi_wdata[65:34], lo_wdata[33:2], hi_we[1], lo_we[0]}
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the address was presented by EX
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- hilo_mem_to_wb_bus  out  66  registered HI/LO bus passed through unchanged
- mem_wreg, mem_waddr[5], mem_wdata[32]  out  forwarding to ID
- mem_hi_we, mem_lo_we, mem_hi_wdata[32], mem_lo_wdata[32]  out  HI/LO forwarding to ID
- mem_opl  out  1  a load occupies MEM and its data is not forwardable; ID must stall a dependent instruction

Behaviour:
- EX/MEM register priority:
  - rst → all bits 0.
  - else stall[3]=Stop and stall[4]=NoStop → bubble (all 0).
  - else stall[3]=NoStop → load ex_to_mem_bus, ex_load_type, hilo bus.
  - else hold.
- Reset values: every output is 0. The buffer is empty.
- is_load = data_ram_en && data_ram_wen==0 && load_type!=0. addr = ex_result.
- Load data source: rdata_sel = buf_valid ? rdata_buf : data_sram_rdata.
- Load-data buffer, 2 states, EMPTY/FULL:
  - EMPTY→FULL: the register did not load or bubble this cycle, is_load, and stall[4]=Stop. Capture data_sram_rdata into rdata_buf.
  - FULL→EMPTY: the register loads new content, bubbles, or rst.
  - FULL holds rdata_buf regardless of data_sram_rdata.
  - Loading the register in the same cycle as the capture condition: the load wins; the buffer stays EMPTY.
- Byte/half extraction, little-endian, combinational:
  - lb/lbu select byte addr[1:0]; sign- or zero-extend.
  - lh/lhu select half addr[1] (0 → [15:0]); sign- or zero-extend.
  - lw uses the full word.
  - Misaligned addresses raise no exception: the low address bits are ignored as above.
- rf_wdata = sel_rf_res ? load_data : ex_result.
- mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata}. Outputs are combinational from the register, so latency is 1 cycle from the EX register.
- Stores: no write-back effect here; rf_we arrives 0 from decode.
- Forwarding outputs mirror mem_to_wb_bus fields and the registered HI/LO bus.

Optional Feature:
- MEM_LOAD_FWD_EN defined:
  - mem_wdata = rf_wdata, including extracted load data.
  - mem_opl tied 0.
- Not defined:
  - mem_wdata = ex_result.
  - mem_opl = is_load.

Decomposition:
- Shared package / lib/defines.vh: EX_TO_MEM_WD, MEM_TO_WB_WD, StallBus, Stop/NoStop, LOAD_* 3-bit encodings, and a bus field-offset localparam list.
- One sub-module: mem_load_align. Purely combinational: {rdata, addr[1:0], load_type} → 32-bit extended data.

Test Plan:
- lb, addr 0x1003, rdata 0x80FF_1234 → rf_wdata 0xFFFF_FF80. Same with lbu → 0x0000_0080.
- lh, addr 0x1002, rdata 0x8001_7FFF → 0xFFFF_8001. lhu, addr 0x1000 → 0x0000_7FFF.
- lw in MEM, stall[4]=Stop for 3 cycles; data_sram_rdata 0xDEAD_BEEF then changes to 0x1111_1111 → WB receives 0xDEAD_BEEF after release; buffer empties.
- stall[3]=Stop, stall[4]=NoStop → next cycle mem_to_wb_bus==0 and hilo bus==0.
- Non-load rf_we=1, waddr 5'd9, ex_result 0x42 → mem_wreg=1, mem_waddr=9, mem_wdata=0x42. hilo hi_we=1, hi 0xABCD → mem_hi_wdata 0xABCD.
- rst asserted mid-stall with buffer FULL → next cycle all outputs 0 and buffer EMPTY. Load in MEM → mem_opl=1 without the macro, 0 with MEM_LOAD_FWD_EN.
